// File: rtl/daq_fifo_rst_pkg.sv
// Shared state encodings, register bundle and parameter limits for the DAQ FIFO
// reset sequencer and its response block (daq_fifo_rst_rsp).
package daq_fifo_rst_pkg;

    localparam int unsigned CYC_MIN = 1;
    localparam int unsigned CYC_MAX = 255;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ASSERT    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_READY     = 3'd4,
        ST_ERR       = 3'd5
    } rsp_state_e;

    // Everything the response block keeps in flops, so it can be voted as one group.
    typedef struct packed {
        rsp_state_e state;
        logic [7:0] cnt;
        logic [7:0] drop_cnt;
        logic       fifo_rst_out;
        logic       ready;
        logic       rst_err;
    } rsp_regs_t;

    localparam rsp_regs_t RSP_REGS_RST = '{
        state:        ST_IDLE,
        cnt:          8'd0,
        drop_cnt:     8'd0,
        fifo_rst_out: 1'b1,
        ready:        1'b0,
        rst_err:      1'b0
    };

    // Out-of-range cycle parameters are pulled back into the legal window.
    function automatic logic [7:0] clamp_cyc(input int unsigned v);
        if (v < CYC_MIN) return 8'(CYC_MIN);
        if (v > CYC_MAX) return 8'(CYC_MAX);
        return 8'(v);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/daq_fifo_rst_rsp_maj3.sv
// Bitwise 2-of-3 majority voter used to protect triplicated register groups.
module maj3 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] y
);

    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/daq_fifo_rst_rsp.sv
// FIFO reset response: stretches the reset, waits out the primitive busy flags, gates
// enables until READY. Define DAQ_RST_RSP_TMR_EN for triplicated, voted registers.
module daq_fifo_rst_rsp
    import daq_fifo_rst_pkg::*;
#(
    parameter int unsigned MIN_RST_CYC = 5,
    parameter int unsigned SETTLE_CYC  = 8,
    parameter int unsigned BUSY_TMO    = 200
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       FIFO_RST,
    input  logic       WR_RST_BUSY,
    input  logic       RD_RST_BUSY,
    input  logic       WR_EN_IN,
    input  logic       RD_EN_IN,
    output logic       FIFO_RST_OUT,
    output logic       WR_EN_OUT,
    output logic       RD_EN_OUT,
    output logic       READY,
    output logic       RST_ERR,
    output logic [7:0] DROP_CNT
);

    localparam logic [7:0] MIN_C    = clamp_cyc(MIN_RST_CYC);
    localparam logic [7:0] SETTLE_C = clamp_cyc(SETTLE_CYC);
    localparam logic [7:0] TMO_C    = clamp_cyc(BUSY_TMO);

    rsp_regs_t regs_v;
    rsp_regs_t regs_d;
    logic      restart;

    // The counter holds cycles spent in the current state, starting at 1 on entry.
    // Registered outputs are decoded from the next state so they move with it.
    always_comb begin
        regs_d  = regs_v;
        restart = FIFO_RST && (regs_v.state != ST_ASSERT);
        if (restart) begin
            regs_d.state = ST_ASSERT;
            regs_d.cnt   = 8'd1;
        end else begin
            case (regs_v.state)
                ST_ASSERT: begin
                    if (!FIFO_RST && (regs_v.cnt >= MIN_C)) begin
                        regs_d.state = ST_WAIT_BUSY;
                        regs_d.cnt   = 8'd1;
                    end else begin
                        regs_d.cnt = sat_inc(regs_v.cnt);
                    end
                end
                ST_WAIT_BUSY: begin
                    if (!WR_RST_BUSY && !RD_RST_BUSY) begin
                        regs_d.state = ST_SETTLE;
                        regs_d.cnt   = 8'd1;
                    end else if (regs_v.cnt >= TMO_C) begin
                        regs_d.state = ST_ERR;
                    end else begin
                        regs_d.cnt = sat_inc(regs_v.cnt);
                    end
                end
                ST_SETTLE: begin
                    if (regs_v.cnt >= SETTLE_C) begin
                        regs_d.state = ST_READY;
                    end else begin
                        regs_d.cnt = sat_inc(regs_v.cnt);
                    end
                end
                ST_IDLE, ST_READY, ST_ERR: ;
                default: begin
                    regs_d.state = ST_IDLE;
                    regs_d.cnt   = 8'd0;
                end
            endcase
        end

        if (restart) begin
            regs_d.drop_cnt = 8'd0;
        end else if (WR_EN_IN && !regs_v.ready) begin
            regs_d.drop_cnt = sat_inc(regs_v.drop_cnt);
        end

        regs_d.fifo_rst_out = (regs_d.state == ST_IDLE) || (regs_d.state == ST_ASSERT) ||
                              (regs_d.state == ST_ERR);
        regs_d.ready        = (regs_d.state == ST_READY);
        if (regs_d.state == ST_ERR) begin
            regs_d.rst_err = 1'b1;
        end else if (restart) begin
            regs_d.rst_err = 1'b0;
        end
    end

`ifdef DAQ_RST_RSP_TMR_EN
    // Three copies all load the voted next value, so one upset copy is repaired next edge.
    (* keep = "true" *) (* preserve *) rsp_regs_t regs_q [3];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 3; i++) begin
                regs_q[i] <= RSP_REGS_RST;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                regs_q[i] <= regs_d;
            end
        end
    end

    maj3 #(
        .WIDTH($bits(rsp_regs_t))
    ) u_regs_vote (
        .a(regs_q[0]),
        .b(regs_q[1]),
        .c(regs_q[2]),
        .y(regs_v)
    );
`else
    rsp_regs_t regs_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            regs_q <= RSP_REGS_RST;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign regs_v = regs_q;
`endif

    assign FIFO_RST_OUT = regs_v.fifo_rst_out;
    assign READY        = regs_v.ready;
    assign RST_ERR      = regs_v.rst_err;
    assign DROP_CNT     = regs_v.drop_cnt;
    assign WR_EN_OUT    = WR_EN_IN && regs_v.ready;
    assign RD_EN_OUT    = RD_EN_IN && regs_v.ready;

endmodule

// File: tb/tb_daq_fifo_rst_rsp.sv
// Bench for daq_fifo_rst_rsp: elapsed-time behavioural model checked every cycle,
// directed sequences with hand-computed timing, then randomized traffic.
`timescale 1ns/1ps
module tb_daq_fifo_rst_rsp;

    localparam int MIN_RST = 5;
    localparam int SETTLE  = 8;
    localparam int TMO     = 200;

    localparam int P_IDLE   = 0;
    localparam int P_ASSERT = 1;
    localparam int P_WAIT   = 2;
    localparam int P_SETTLE = 3;
    localparam int P_READY  = 4;
    localparam int P_ERR    = 5;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       fifo_rst = 1'b0;
    logic       wr_busy  = 1'b0;
    logic       rd_busy  = 1'b0;
    logic       wr_en_in = 1'b0;
    logic       rd_en_in = 1'b0;
    logic       fifo_rst_out;
    logic       wr_en_out;
    logic       rd_en_out;
    logic       ready;
    logic       rst_err;
    logic [7:0] drop_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int m_phase      = P_IDLE;
    int m_enter      = 0;
    int m_spent      = 0;
    int m_drops      = 0;
    int m_err        = 0;
    bit checking     = 1'b0;

    always #5 clk = ~clk;

    daq_fifo_rst_rsp #(
        .MIN_RST_CYC(MIN_RST),
        .SETTLE_CYC (SETTLE),
        .BUSY_TMO   (TMO)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .FIFO_RST    (fifo_rst),
        .WR_RST_BUSY (wr_busy),
        .RD_RST_BUSY (rd_busy),
        .WR_EN_IN    (wr_en_in),
        .RD_EN_IN    (rd_en_in),
        .FIFO_RST_OUT(fifo_rst_out),
        .WR_EN_OUT   (wr_en_out),
        .RD_EN_OUT   (rd_en_out),
        .READY       (ready),
        .RST_ERR     (rst_err),
        .DROP_CNT    (drop_cnt)
    );

    function automatic void check_val(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Model tracks the phase and the edge it was entered on; time in phase is plain subtraction.
    task automatic model_step();
        if (rst) begin
            m_phase = P_IDLE;
            m_drops = 0;
            m_err   = 0;
            m_enter = cyc;
        end else begin
            cyc++;
            m_spent = cyc - m_enter;
            if (fifo_rst && m_phase != P_ASSERT) begin
                m_phase = P_ASSERT;
                m_enter = cyc;
                m_drops = 0;
                m_err   = 0;
            end else begin
                if (wr_en_in && m_phase != P_READY) m_drops++;
                case (m_phase)
                    P_ASSERT: if (!fifo_rst && m_spent >= MIN_RST) begin
                        m_phase = P_WAIT;
                        m_enter = cyc;
                    end
                    P_WAIT: if (!wr_busy && !rd_busy) begin
                        m_phase = P_SETTLE;
                        m_enter = cyc;
                    end else if (m_spent >= TMO) begin
                        m_phase = P_ERR;
                        m_enter = cyc;
                        m_err   = 1;
                    end
                    P_SETTLE: if (m_spent >= SETTLE) begin
                        m_phase = P_READY;
                        m_enter = cyc;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_output();
        int exp_rst_out;
        int exp_ready;
        exp_rst_out = (m_phase == P_IDLE || m_phase == P_ASSERT || m_phase == P_ERR) ? 1 : 0;
        exp_ready   = (m_phase == P_READY) ? 1 : 0;
        check_val("fifo_rst_out", int'(fifo_rst_out), exp_rst_out);
        check_val("ready", int'(ready), exp_ready);
        check_val("rst_err", int'(rst_err), m_err);
        check_val("drop_cnt", int'(drop_cnt), (m_drops > 255) ? 255 : m_drops);
        check_val("wr_en_out", int'(wr_en_out), int'(wr_en_in) & exp_ready);
        check_val("rd_en_out", int'(rd_en_out), int'(rd_en_in) & exp_ready);
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (checking) check_output();
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_ready(input string name, input int limit);
        for (int i = 0; i < limit && !ready; i++) step(1);
        check_val(name, int'(ready), 1);
    endtask

    task automatic apply_stimulus(input int cycles);
        int mode;
        int hold;
        mode = 0;
        hold = 0;
        for (int i = 0; i < cycles; i++) begin
            if (i % 256 == 0) mode = int'($urandom_range(0, 3));
            if (hold > 0) hold--;
            else if (mode != 1 && $urandom_range(0, 99) < 2) hold = int'($urandom_range(1, 12));
            fifo_rst = (hold > 0);
            case (mode)
                0: begin
                    wr_busy = ($urandom_range(0, 3) == 0);
                    rd_busy = ($urandom_range(0, 3) == 0);
                end
                1: begin
                    wr_busy = 1'b0;
                    rd_busy = 1'b1;
                end
                2: begin
                    wr_busy = 1'b0;
                    rd_busy = 1'b0;
                end
                default: begin
                    wr_busy = ($urandom_range(0, 1) == 0);
                    rd_busy = 1'b0;
                end
            endcase
            wr_en_in = ($urandom_range(0, 1) == 1);
            rd_en_in = ($urandom_range(0, 1) == 1);
            step(1);
        end
    endtask

    initial begin
        int fall;
        int rise;
        int err_at;
        int wr_out_high;

        step(3);
        rst = 1'b0;
        checking = 1'b1;
        check_val("reset_fifo_rst_out", int'(fifo_rst_out), 1);
        check_val("reset_ready", int'(ready), 0);
        check_val("reset_rst_err", int'(rst_err), 0);
        check_val("reset_drop_cnt", int'(drop_cnt), 0);

        // Short request: ASSERT entered on edge 1, released edge 6, READY edge 15.
        fifo_rst = 1'b1;
        fall = 0;
        rise = 0;
        for (int e = 1; e <= 40 && rise == 0; e++) begin
            step(1);
            if (e == 3) fifo_rst = 1'b0;
            if (fall == 0 && !fifo_rst_out) fall = e;
            if (rise == 0 && ready) rise = e;
        end
        check_val("short_rst_release_edge", fall, 6);
        check_val("short_ready_edge", rise, 15);

        // Long request with write busy held 30 cycles past release.
        fifo_rst = 1'b1;
        wr_busy  = 1'b1;
        fall = 0;
        rise = 0;
        for (int e = 1; e <= 90 && rise == 0; e++) begin
            step(1);
            if (e == 20) fifo_rst = 1'b0;
            if (e == 50) wr_busy = 1'b0;
            if (fall == 0 && !fifo_rst_out) fall = e;
            if (rise == 0 && ready) rise = e;
        end
        check_val("long_rst_release_edge", fall, 21);
        check_val("long_ready_edge", rise, 59);

        // Read busy stuck: timeout after 200 cycles of waiting, then a new request recovers.
        fifo_rst = 1'b1;
        rd_busy  = 1'b1;
        err_at = 0;
        for (int e = 1; e <= 260 && err_at == 0; e++) begin
            step(1);
            if (e == 3) fifo_rst = 1'b0;
            if (err_at == 0 && rst_err) err_at = e;
        end
        check_val("timeout_err_edge", err_at, 206);
        check_val("timeout_err_rst_out", int'(fifo_rst_out), 1);
        fifo_rst = 1'b1;
        step(1);
        check_val("restart_clears_err", int'(rst_err), 0);
        check_val("restart_rst_out", int'(fifo_rst_out), 1);
        fifo_rst = 1'b0;
        rd_busy  = 1'b0;
        wait_ready("recover_ready", 40);

        // Request pulse in the 4th SETTLE cycle reissues the full reset pulse.
        fifo_rst = 1'b1;
        fall = 0;
        rise = 0;
        for (int e = 1; e <= 60 && rise == 0; e++) begin
            step(1);
            if (e == 3) fifo_rst = 1'b0;
            if (e == 10) fifo_rst = 1'b1;
            if (e == 11) begin
                fifo_rst = 1'b0;
                check_val("settle_restart_rst_out", int'(fifo_rst_out), 1);
            end
            if (e > 11 && fall == 0 && !fifo_rst_out) fall = e;
            if (e > 11 && rise == 0 && ready) rise = e;
        end
        check_val("settle_restart_release_edge", fall, 16);
        check_val("settle_restart_ready_edge", rise, 25);

        // Writes while not ready are dropped and counted, saturating at 255.
        fifo_rst    = 1'b1;
        wr_en_in    = 1'b1;
        wr_out_high = 0;
        for (int e = 1; e <= 300; e++) begin
            step(1);
            if (wr_en_out) wr_out_high++;
        end
        check_val("drop_wr_en_out_high_cycles", wr_out_high, 0);
        check_val("drop_cnt_saturated", int'(drop_cnt), 255);
        fifo_rst = 1'b0;
        wr_en_in = 1'b0;
        wait_ready("drop_recover_ready", 40);
        check_val("drop_cnt_kept_in_ready", int'(drop_cnt), 255);

        apply_stimulus(1500);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        apply_stimulus(1500);

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
